rom_dl_ctrl: RTL and testbench



---
 rtl/rom_dl_pkg.sv | 8 +
 rtl/rom_dl_hold_timer.sv | 15 +
 rtl/rom_dl_ctrl.sv | 119 +++++++++++
 tb/tb_rom_dl_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_dl_pkg.sv
// rom_dl_pkg: shared FSM state type, ioctl image indices and default image sizes for the ROM download sequencer
package rom_dl_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, HOLD, RUN} dl_state_t;
  localparam logic [7:0] IDX_MAIN = 8'd0;
  localparam logic [7:0] IDX_SND = 8'd1;
  localparam int MAIN_SIZE_DEF = 'hF000;
  localparam int SND_SIZE_DEF = 'h2000;
endpackage

// File: rtl/rom_dl_hold_timer.sv
// rom_dl_hold_timer: loads CYCLES-1 on load, counts down to zero and holds there; done while the count is zero
module rom_dl_hold_timer #(
  parameter int CYCLES = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic done
);
  localparam int W = CYCLES > 1 ? $clog2(CYCLES) : 1;
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? W'(CYCLES - 1) : (cnt_q != '0 ? cnt_q - 1'b1 : cnt_q);
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
  assign done = cnt_q == '0;
endmodule

// File: rtl/rom_dl_ctrl.sv
// rom_dl_ctrl: ioctl ROM download sequencer (write steering, load tracking, CPU reset hold); checksum judging enabled by ROM_DL_CKSUM_EN
module rom_dl_ctrl
  import rom_dl_pkg::*;
#(
  parameter int         MAIN_SIZE   = MAIN_SIZE_DEF,
  parameter int         SND_SIZE    = SND_SIZE_DEF,
  parameter int         HOLD_CYCLES = 256,
  parameter logic [7:0] CKSUM_MAIN  = 8'h00
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic [24:0] dl_addr,
  output logic [7:0]  dl_data,
  output logic        dl_wr_main,
  output logic        dl_wr_snd,
  output logic        core_reset,
  output logic        rom_ready,
  output logic        dl_err,
  output logic [7:0]  dl_sum
);
  dl_state_t state_q, state_d;
  logic dl_q, idx_q, idx_d;
  logic [16:0] cnt_main_q, cnt_main_d, cnt_snd_q, cnt_snd_d, cnt_cur, cnt_nxt;
  logic ld_main_q, ld_main_d, ld_snd_q, ld_snd_d, err_q, err_d;
  logic [24:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic wr_main_q, wr_main_d, wr_snd_q, wr_snd_d;
  logic rise, fall, rise_ok, wr_ok, in_range, hit, fall_load, img_ok, sum_ok;
  logic hold_load, hold_done;
  assign rise = ioctl_download & ~dl_q;
  assign fall = ~ioctl_download & dl_q;
  assign rise_ok = rise & (ioctl_index == IDX_MAIN || ioctl_index == IDX_SND);
`ifdef ROM_DL_CKSUM_EN
  logic [7:0] sum_q, sum_d, sum_base;
  always_comb begin
    sum_base = (rise_ok && !idx_d) ? 8'h00 : sum_q;
    sum_d = (hit && !idx_d) ? sum_base + ioctl_dout : sum_base;
    sum_ok = idx_q || sum_q == CKSUM_MAIN;
  end
  always_ff @(posedge CLK) sum_q <= RESET ? 8'h00 : sum_d;
  assign dl_sum = sum_q;
`else
  logic unused_cksum;
  assign unused_cksum = ^CKSUM_MAIN;
  assign sum_ok = 1'b1;
  assign dl_sum = 8'h00;
`endif
  // idx_d already reflects a same-cycle rise so a write arriving with the rise is steered to the new image
  always_comb begin
    idx_d = rise_ok ? ioctl_index == IDX_SND : idx_q;
    wr_ok = (rise_ok || state_q == LOAD) && ioctl_wr && ioctl_download;
    in_range = ioctl_addr < (idx_d ? 25'(SND_SIZE) : 25'(MAIN_SIZE));
    hit = wr_ok && in_range;
    cnt_cur = rise_ok ? '0 : (idx_d ? cnt_snd_q : cnt_main_q);
    cnt_nxt = (hit && cnt_cur != '1) ? cnt_cur + 1'b1 : cnt_cur;
    cnt_main_d = idx_d ? cnt_main_q : cnt_nxt;
    cnt_snd_d = idx_d ? cnt_nxt : cnt_snd_q;
    fall_load = state_q == LOAD && fall;
    img_ok = !err_q && sum_ok && cnt_cur == (idx_q ? 17'(SND_SIZE) : 17'(MAIN_SIZE));
    ld_main_d = (rise_ok && !idx_d) ? 1'b0 : (fall_load && !idx_q && img_ok) ? 1'b1 : ld_main_q;
    ld_snd_d = (rise_ok && idx_d) ? 1'b0 : (fall_load && idx_q && img_ok) ? 1'b1 : ld_snd_q;
    err_d = (rise_ok ? 1'b0 : err_q) | (wr_ok && !in_range) | (fall_load && !img_ok);
    addr_d = hit ? ioctl_addr : addr_q;
    data_d = hit ? ioctl_dout : data_q;
    wr_main_d = hit && !idx_d;
    wr_snd_d = hit && idx_d;
    state_d = rise_ok ? LOAD :
              fall_load ? ((ld_main_d && ld_snd_d) ? HOLD : IDLE) :
              (state_q == HOLD && hold_done) ? RUN : state_q;
    hold_load = state_d == HOLD && state_q != HOLD;
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      dl_q <= 1'b0;
      idx_q <= 1'b0;
      cnt_main_q <= '0;
      cnt_snd_q <= '0;
      ld_main_q <= 1'b0;
      ld_snd_q <= 1'b0;
      err_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      wr_main_q <= 1'b0;
      wr_snd_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dl_q <= ioctl_download;
      idx_q <= idx_d;
      cnt_main_q <= cnt_main_d;
      cnt_snd_q <= cnt_snd_d;
      ld_main_q <= ld_main_d;
      ld_snd_q <= ld_snd_d;
      err_q <= err_d;
      addr_q <= addr_d;
      data_q <= data_d;
      wr_main_q <= wr_main_d;
      wr_snd_q <= wr_snd_d;
    end
  end
  rom_dl_hold_timer #(.CYCLES(HOLD_CYCLES)) u_hold (
    .clk  (CLK),
    .rst  (RESET),
    .load (hold_load),
    .done (hold_done)
  );
  assign dl_addr = addr_q;
  assign dl_data = data_q;
  assign dl_wr_main = wr_main_q;
  assign dl_wr_snd = wr_snd_q;
  assign dl_err = err_q;
  assign core_reset = state_q != RUN;
  assign rom_ready = state_q == RUN;
endmodule

// File: tb/tb_rom_dl_ctrl.sv
// tb_rom_dl_ctrl: scoreboard bench for rom_dl_ctrl (reduced image sizes, default hold length)
module tb_rom_dl_ctrl;
  import rom_dl_pkg::*;
  localparam int MS = 'h2000;
  localparam int SS = 'h800;
  localparam int HC = 256;
  localparam logic [7:0] CK = 8'h5A;
  logic CLK, RESET, ioctl_download, ioctl_wr;
  logic [7:0] ioctl_index, ioctl_dout, dl_data, dl_sum;
  logic [24:0] ioctl_addr, dl_addr;
  logic dl_wr_main, dl_wr_snd, core_reset, rom_ready, dl_err;
  typedef struct {
    bit          snd;
    logic [24:0] a;
    logic [7:0]  d;
    int          cyc;
  } exp_t;
  exp_t sb[$];
  exp_t e_m;
  int compared = 0, mismatched = 0, cyc = 0, n_main = 0, n_snd = 0;
  logic cr_rise, rr_rise, err_rise;
  rom_dl_ctrl #(.MAIN_SIZE(MS), .SND_SIZE(SS), .HOLD_CYCLES(HC), .CKSUM_MAIN(CK)) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .dl_addr        (dl_addr),
    .dl_data        (dl_data),
    .dl_wr_main     (dl_wr_main),
    .dl_wr_snd      (dl_wr_snd),
    .core_reset     (core_reset),
    .rom_ready      (rom_ready),
    .dl_err         (dl_err),
    .dl_sum         (dl_sum)
  );
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  always @(negedge CLK) begin
    if (dl_wr_main || dl_wr_snd) begin
      n_main += int'(dl_wr_main);
      n_snd += int'(dl_wr_snd);
      compared++;
      if (sb.size() == 0) begin
        mismatched++;
        $display("FAIL strobe_unexpected: got main=%0b snd=%0b addr=%h data=%h at cycle %0d, want no strobe", dl_wr_main, dl_wr_snd, dl_addr, dl_data, cyc);
      end else begin
        e_m = sb.pop_front();
        if ({dl_wr_snd, dl_wr_main, dl_addr, dl_data} !== {e_m.snd, !e_m.snd, e_m.a, e_m.d} || cyc != e_m.cyc) begin
          mismatched++;
          $display("FAIL strobe: got snd=%0b main=%0b addr=%h data=%h cyc=%0d, want snd=%0b addr=%h data=%h cyc=%0d", dl_wr_snd, dl_wr_main, dl_addr, dl_data, cyc, e_m.snd, e_m.a, e_m.d, e_m.cyc);
        end
      end
    end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
      compared++;
      mismatched++;
      $display("FAIL strobe_missing: got none at cycle %0d, want addr=%h data=%h", cyc, sb[0].a, sb[0].d);
      e_m = sb.pop_front();
    end
  end
  task automatic load(input logic [7:0] idx, input int n, input bit acc, input logic [7:0] tgt, input int bad_at, input bit wr_rise, input bit wr_fall);
    logic [7:0] s, d;
    logic [24:0] lim;
    int a;
    exp_t e;
    s = 8'h00;
    a = 0;
    lim = idx == 8'd1 ? 25'(SS) : 25'(MS);
    @(negedge CLK);
    ioctl_index = idx;
    ioctl_download = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (!(i == 0 && wr_rise)) @(negedge CLK);
      if (i == (wr_rise ? 1 : 0)) begin
        cr_rise = core_reset;
        rr_rise = rom_ready;
        err_rise = dl_err;
      end
      if (i == bad_at) begin
        ioctl_addr = lim;
        ioctl_dout = 8'hEE;
      end else begin
        d = (i == n - 1) ? tgt - s : 8'($urandom);
        s += d;
        ioctl_addr = 25'(a);
        ioctl_dout = d;
        if (acc) begin
          e.snd = idx == 8'd1;
          e.a = 25'(a);
          e.d = d;
          e.cyc = cyc + 1;
          sb.push_back(e);
        end
        a++;
      end
      ioctl_wr = 1'b1;
    end
    @(negedge CLK);
    ioctl_download = 1'b0;
    ioctl_wr = wr_fall;
    ioctl_addr = '0;
    ioctl_dout = 8'h11;
    @(negedge CLK);
    ioctl_wr = 1'b0;
  endtask
  task automatic wait_run(input string tag);
    int n = 0;
    while (core_reset === 1'b1 && n < 2000) begin
      @(negedge CLK);
      n++;
    end
    compared++;
    if (n != HC || rom_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL %s_hold: got %0d cycles rom_ready=%b, want %0d cycles rom_ready=1", tag, n, rom_ready, HC);
    end
  endtask
  task automatic test_reset();
    RESET = 1'b1;
    repeat (3) @(negedge CLK);
    compared++;
    if ({core_reset, rom_ready, dl_err, dl_wr_main, dl_wr_snd, dl_addr, dl_data, dl_sum} !== {5'b10000, 25'd0, 8'd0, 8'd0}) begin
      mismatched++;
      $display("FAIL reset_outputs: got cr=%b rr=%b err=%b wm=%b ws=%b addr=%h data=%h sum=%h, want cr=1 others 0", core_reset, rom_ready, dl_err, dl_wr_main, dl_wr_snd, dl_addr, dl_data, dl_sum);
    end
    compared++;
    if (dut.state_q !== IDLE) begin
      mismatched++;
      $display("FAIL reset_state: got %s want IDLE", dut.state_q.name());
    end
    RESET = 1'b0;
    @(negedge CLK);
  endtask
  task automatic test_truncated();
    int m0 = n_main;
    load(8'd0, 4096, 1'b1, CK, -1, 1'b0, 1'b0);
    compared++;
    if (dl_err !== 1'b1 || rom_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL trunc_err: got err=%b rr=%b, want err=1 rr=0", dl_err, rom_ready);
    end
    compared++;
    if (dut.state_q !== IDLE) begin
      mismatched++;
      $display("FAIL trunc_state: got %s want IDLE", dut.state_q.name());
    end
    compared++;
    if (n_main - m0 != 4096) begin
      mismatched++;
      $display("FAIL trunc_pulses: got %0d want 4096", n_main - m0);
    end
  endtask
  task automatic test_full_main();
    int m0 = n_main;
    logic [7:0] want_sum;
`ifdef ROM_DL_CKSUM_EN
    want_sum = CK;
`else
    want_sum = 8'h00;
`endif
    load(8'd0, MS, 1'b1, CK, -1, 1'b0, 1'b0);
    compared++;
    if (err_rise !== 1'b0) begin
      mismatched++;
      $display("FAIL main_err_clear: got %b after rise, want 0", err_rise);
    end
    compared++;
    if (dl_err !== 1'b0 || dut.state_q !== IDLE || rom_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL main_done: got err=%b state=%s rr=%b, want err=0 IDLE rr=0", dl_err, dut.state_q.name(), rom_ready);
    end
    compared++;
    if (n_main - m0 != MS || dl_addr !== 25'(MS - 1)) begin
      mismatched++;
      $display("FAIL main_pulses: got %0d last addr %h, want %0d last addr %h", n_main - m0, dl_addr, MS, MS - 1);
    end
    compared++;
    if (dl_sum !== want_sum) begin
      mismatched++;
      $display("FAIL main_sum: got %h want %h", dl_sum, want_sum);
    end
  endtask
  task automatic test_full_snd();
    int s0 = n_snd;
    load(8'd1, SS, 1'b1, 8'h00, -1, 1'b0, 1'b0);
    compared++;
    if (dl_err !== 1'b0 || dut.state_q !== HOLD || n_snd - s0 != SS) begin
      mismatched++;
      $display("FAIL snd_done: got err=%b state=%s pulses=%0d, want err=0 HOLD %0d", dl_err, dut.state_q.name(), n_snd - s0, SS);
    end
    wait_run("snd");
  endtask
  task automatic test_ignored_index();
    int m0 = n_main, s0 = n_snd;
    load(8'd3, 100, 1'b0, 8'h00, -1, 1'b0, 1'b0);
    compared++;
    if (dut.state_q !== RUN || core_reset !== 1'b0 || rom_ready !== 1'b1 || dl_err !== 1'b0) begin
      mismatched++;
      $display("FAIL ignored_state: got state=%s cr=%b rr=%b err=%b, want RUN 0 1 0", dut.state_q.name(), core_reset, rom_ready, dl_err);
    end
    compared++;
    if (n_main != m0 || n_snd != s0) begin
      mismatched++;
      $display("FAIL ignored_strobes: got %0d/%0d pulses, want 0/0", n_main - m0, n_snd - s0);
    end
  endtask
  task automatic test_reload();
    load(8'd1, SS, 1'b1, 8'h00, -1, 1'b0, 1'b0);
    compared++;
    if (cr_rise !== 1'b1 || rr_rise !== 1'b0) begin
      mismatched++;
      $display("FAIL reload_rise: got cr=%b rr=%b after rise, want cr=1 rr=0", cr_rise, rr_rise);
    end
    compared++;
    if (dut.state_q !== HOLD || dl_err !== 1'b0) begin
      mismatched++;
      $display("FAIL reload_done: got state=%s err=%b, want HOLD 0", dut.state_q.name(), dl_err);
    end
    wait_run("reload");
  endtask
  task automatic test_out_of_range();
    int s0 = n_snd;
    load(8'd1, SS + 1, 1'b1, 8'h00, SS / 2, 1'b0, 1'b0);
    compared++;
    if (dl_err !== 1'b1 || dut.state_q !== IDLE || rom_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL oor_err: got err=%b state=%s rr=%b, want err=1 IDLE rr=0", dl_err, dut.state_q.name(), rom_ready);
    end
    compared++;
    if (n_snd - s0 != SS) begin
      mismatched++;
      $display("FAIL oor_pulses: got %0d want %0d", n_snd - s0, SS);
    end
  endtask
  task automatic test_edge_writes();
    int s0 = n_snd;
    load(8'd1, SS, 1'b1, 8'h00, -1, 1'b1, 1'b1);
    compared++;
    if (err_rise !== 1'b0) begin
      mismatched++;
      $display("FAIL edge_err_clear: got %b want 0", err_rise);
    end
    compared++;
    if (dut.state_q !== HOLD || n_snd - s0 != SS || dl_addr !== 25'(SS - 1)) begin
      mismatched++;
      $display("FAIL edge_done: got state=%s pulses=%0d addr=%h, want HOLD %0d addr %h", dut.state_q.name(), n_snd - s0, dl_addr, SS, SS - 1);
    end
    wait_run("edge");
  endtask
`ifdef ROM_DL_CKSUM_EN
  task automatic test_cksum();
    load(8'd0, MS, 1'b1, 8'h5B, -1, 1'b0, 1'b0);
    compared++;
    if (dl_err !== 1'b1 || dl_sum !== 8'h5B || dut.state_q !== IDLE) begin
      mismatched++;
      $display("FAIL cksum: got err=%b sum=%h state=%s, want err=1 sum=5b IDLE", dl_err, dl_sum, dut.state_q.name());
    end
  endtask
`endif
  task automatic test_reset_mid_load();
    exp_t e;
    @(negedge CLK);
    ioctl_index = 8'd0;
    ioctl_download = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      ioctl_wr = 1'b1;
      ioctl_addr = 25'(i);
      ioctl_dout = 8'(i + 3);
      e.snd = 1'b0;
      e.a = 25'(i);
      e.d = 8'(i + 3);
      e.cyc = cyc + 1;
      sb.push_back(e);
    end
    @(negedge CLK);
    ioctl_wr = 1'b0;
    ioctl_download = 1'b0;
    RESET = 1'b1;
    @(negedge CLK);
    compared++;
    if ({core_reset, rom_ready, dl_err, dl_wr_main, dl_wr_snd, dl_addr, dl_data, dl_sum} !== {5'b10000, 25'd0, 8'd0, 8'd0}) begin
      mismatched++;
      $display("FAIL midreset_outputs: got cr=%b rr=%b err=%b wm=%b ws=%b addr=%h data=%h sum=%h, want cr=1 others 0", core_reset, rom_ready, dl_err, dl_wr_main, dl_wr_snd, dl_addr, dl_data, dl_sum);
    end
    compared++;
    if (dut.state_q !== IDLE || {dut.ld_main_q, dut.ld_snd_q} !== 2'b00) begin
      mismatched++;
      $display("FAIL midreset_state: got state=%s flags=%b%b, want IDLE 00", dut.state_q.name(), dut.ld_main_q, dut.ld_snd_q);
    end
    RESET = 1'b0;
    repeat (5) @(negedge CLK);
    compared++;
    if (dut.state_q !== IDLE || core_reset !== 1'b1) begin
      mismatched++;
      $display("FAIL midreset_after: got state=%s cr=%b, want IDLE 1", dut.state_q.name(), core_reset);
    end
  endtask
  initial begin
    RESET = 1'b1;
    ioctl_download = 1'b0;
    ioctl_index = 8'd0;
    ioctl_wr = 1'b0;
    ioctl_addr = '0;
    ioctl_dout = 8'h00;
    test_reset();
    test_truncated();
    test_full_main();
    test_full_snd();
    test_ignored_index();
    test_reload();
    test_out_of_range();
    test_edge_writes();
`ifdef ROM_DL_CKSUM_EN
    test_cksum();
`endif
    test_reset_mid_load();
    repeat (2) @(negedge CLK);
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout at cycle %0d, want completion", cyc);
    $fatal(1, "watchdog");
  end
endmodule
